alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational alu (ADD/MUL/DIV, flags N,Z,C,V) between NREQ requesters.
//  Round-robin grant, operand capture, registered ALU drive, settle wait,
//  result+flag capture, response return with requester id.
//  Sits between core issue ports and the alu instance.
// PARAMETERS
//  WIDTH   31  MSB index of operands/result (data is WIDTH+1 bits)
//  NREQ    2   number of requesters (2..8)
//  ALU_LAT 1   cycles alu inputs are held before result capture (>=1)
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              async active-low reset
//  req_valid  in   NREQ           request pending per requester
//  req_ready  out  NREQ           one-hot accept pulse
//  req_a      in   NREQ*(WIDTH+1) operand A, slice i for requester i
//  req_b      in   NREQ*(WIDTH+1) operand B
//  req_op     in   NREQ*2         opcode
//  req_ci     in   NREQ           carry-in
//  rsp_valid  out  1              response available
//  rsp_ready  in   1              response consumed
//  rsp_id     out  $clog2(NREQ)   requester index of response
//  rsp_out    out  WIDTH+1        alu result
//  rsp_flags  out  4              {N,Z,C,V} = {negativo,cero,acarreo,desbordamiento}
//  rsp_err    out  1              op rejected, result not computed
//  alu_a/alu_b out WIDTH+1  registered operands to alu; alu_op out 2; alu_ci out 1
//  alu_out    in   WIDTH+1  alu result; alu_co in 1 (unused, C taken from acarreo)
//  alu_neg/alu_zero/alu_carry/alu_ovf  in 1 each  alu flags
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, counter 0; takes effect immediately.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, grant first valid at/after rr pointer; req_ready[g]=1 same
//   cycle (comb, IDLE only); operands/op/ci of g into alu_* regs, id into rsp_id;
//   pointer <= g+1 mod NREQ; -> WAIT, count=0. No req_valid: stay, alu_* hold.
//  WAIT: alu_* stable; count++ ; at count==ALU_LAT-1 capture alu_out and flags into
//   rsp_out/rsp_flags, rsp_err=0 -> RESP. rsp_valid rises ALU_LAT+1 cycles after accept.
//  RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then -> IDLE,
//   rsp_valid=0 next cycle. No accept in RESP; min issue period ALU_LAT+2 cycles.
//  Op 2'b11 (reserved): accepted, alu not driven (alu_* hold), skip WAIT -> RESP next
//   cycle with rsp_out=0, rsp_flags=0, rsp_err=1.
//  req_valid drop without req_ready: legal, no state change. Widths: no extension;
//   rsp_out is alu_out verbatim.
//  Reset mid-WAIT/RESP: transaction discarded, no response emitted.
// CONFIGURATION
//  ALU_DIVZERO_EN defined: DIV (2'b10) with B==0 treated as reserved op: RESP next
//   cycle, rsp_err=1, rsp_out=0, flags=0, alu not driven.
//  Undefined: DIV by zero issued to alu normally; result/flags passed through, rsp_err=0.
// STRUCTURE
//  alu_pkg: op_e {OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSV=2'b11},
//   arb_state_e {IDLE,WAIT,RESP}, FLAG_N=3/FLAG_Z=2/FLAG_C=1/FLAG_V=0.
//  Sub-module rr_arbiter #(NREQ): req vector + pointer -> one-hot grant + index.
//  Top holds FSM, counter, operand/result registers.
// TESTING
//  1 req0 a=7 b=2 op=ADD ci=0 -> rsp_out=9, flags=4'b0000, id=0, err=0, valid at accept+2 (ALU_LAT=1).
//  2 req0,req1 valid same cycle, ptr=0 -> req0 granted first, req1 next IDLE; then
//   ptr=0 again -> both valid: req0 wins (ptr advanced past 1).
//  3 req1 a=5 b=5 MUL, rsp_ready low 10 cycles -> rsp_out=25, all rsp_* stable, no new req_ready.
//  4 req0 op=2'b11 -> rsp_err=1, rsp_out=0, flags=0, rsp_valid at accept+1, alu_* unchanged.
//  5 DIV a=13 b=0: with ALU_DIVZERO_EN -> rsp_err=1; without -> err=0, alu result passed.
//  6 rst_n low during WAIT -> outputs 0 at once, no rsp_valid after release, next req id correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Opcode encoding, arbiter FSM state encoding and response flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef logic [1:0] arb_state_e;

    localparam arb_state_e IDLE = 2'd0;
    localparam arb_state_e WAIT = 2'd1;
    localparam arb_state_e RESP = 2'd2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request at or after the pointer
// wins, searching upward and wrapping at NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IdxW:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NREQ)) begin
                cand = cand - (IdxW + 1)'(NREQ);
            end
            if (!valid_o && req_i[cand[IdxW-1:0]]) begin
                valid_o                 = 1'b1;
                grant_o[cand[IdxW-1:0]] = 1'b1;
                idx_o                   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin accept, registered
// ALU drive, settle wait, result capture, response hand-back. Option: ALU_DIVZERO_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 31,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    input  logic [NREQ*2-1:0]         req_op,
    input  logic [NREQ-1:0]           req_ci,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH:0]            rsp_out,
    output logic [3:0]                rsp_flags,
    output logic                      rsp_err,
    output logic [WIDTH:0]            alu_a,
    output logic [WIDTH:0]            alu_b,
    output logic [1:0]                alu_op,
    output logic                      alu_ci,
    input  logic [WIDTH:0]            alu_out,
    input  logic                      alu_co,
    input  logic                      alu_neg,
    input  logic                      alu_zero,
    input  logic                      alu_carry,
    input  logic                      alu_ovf
);

    localparam int unsigned DW   = WIDTH + 1;
    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(ALU_LAT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            alu_ci_q, alu_ci_d;
    logic [IdxW-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_out_q, rsp_out_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] grant;
    logic [IdxW-1:0] grant_idx;
    logic            grant_vld;

    logic [DW-1:0]   a_sel, b_sel;
    logic [1:0]      op_sel;
    logic            ci_sel;
    logic            reject;

    // Carry comes from the dedicated flag input; the raw carry-out is not needed.
    logic            unused_co;
    assign unused_co = alu_co;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .valid_o (grant_vld)
    );

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        ci_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel  = req_a[i*DW +: DW];
                b_sel  = req_b[i*DW +: DW];
                op_sel = req_op[i*2 +: 2];
                ci_sel = req_ci[i];
            end
        end
    end

`ifdef ALU_DIVZERO_EN
    assign reject = (op_sel == OP_RSV) || ((op_sel == OP_DIV) && (b_sel == '0));
`else
    assign reject = (op_sel == OP_RSV);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_ci_d    = alu_ci_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ptr_d    = (grant_idx == IdxLast) ? '0 : grant_idx + 1'b1;
                    rsp_id_d = grant_idx;
                    cnt_d    = '0;
                    if (reject) begin
                        // Rejected ops never touch the ALU; answer on the next cycle.
                        rsp_out_d   = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_a_d  = a_sel;
                        alu_b_d  = b_sel;
                        alu_op_d = op_sel;
                        alu_ci_d = ci_sel;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CntLast) begin
                    rsp_out_d           = alu_out;
                    rsp_flags_d[FLAG_N] = alu_neg;
                    rsp_flags_d[FLAG_Z] = alu_zero;
                    rsp_flags_d[FLAG_C] = alu_carry;
                    rsp_flags_d[FLAG_V] = alu_ovf;
                    rsp_err_d           = 1'b0;
                    rsp_valid_d         = 1'b1;
                    state_d             = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_ci_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_ci_q    <= alu_ci_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Accept pulse is combinational, so it is masked while reset is held.
    assign req_ready = (rst_n && (state_q == IDLE)) ? grant : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_ci    = alu_ci_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model on the alu_* side.
// Expected values are hand-computed; the DIV-by-zero case follows ALU_DIVZERO_EN.
module tb_alu_arbiter;

    localparam int unsigned W    = 32;
    localparam int unsigned NREQ = 2;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_a;
    logic [2*W-1:0]  req_b;
    logic [3:0]      req_op;
    logic [1:0]      req_ci;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [W-1:0]    rsp_out;
    logic [3:0]      rsp_flags;
    logic            rsp_err;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [1:0]      alu_op;
    logic            alu_ci;
    logic [W-1:0]    alu_out;
    logic            alu_co;
    logic            alu_neg;
    logic            alu_zero;
    logic            alu_carry;
    logic            alu_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(
        .WIDTH   (W - 1),
        .NREQ    (NREQ),
        .ALU_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_ci    (alu_ci),
        .alu_out   (alu_out),
        .alu_co    (alu_co),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_ovf   (alu_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; DIV by zero returns all ones.
    logic [W:0] sum;
    always_comb begin
        sum       = '0;
        alu_out   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op)
            2'b00: begin
                sum       = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ci};
                alu_out   = sum[W-1:0];
                alu_carry = sum[W];
                alu_ovf   = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
            end
            2'b01: alu_out = alu_a * alu_b;
            2'b10: alu_out = (alu_b == '0) ? '1 : alu_a / alu_b;
            default: alu_out = '0;
        endcase
        alu_co   = alu_carry;
        alu_neg  = alu_out[W-1];
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic ci);
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_op[id*2 +: 2] = op;
        req_ci[id]        = ci;
        req_valid[id]     = 1'b1;
    endtask

    // Called just after the accept edge; counts negedges until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, " valid drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic run_txn(input string tag, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] op, input logic ci,
                           input int exp_lat, input logic [W-1:0] exp_out,
                           input logic [3:0] exp_flags, input logic exp_err);
        int lat;
        @(negedge clk);
        set_req(id, a, b, op, ci);
        #1 check({tag, " ready"}, 64'(req_ready), 64'(2'b01 << id));
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        wait_rsp(lat);
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " rsp"}, {rsp_id, rsp_err, rsp_flags, rsp_out},
              {1'(id), exp_err, exp_flags, exp_out});
        consume(tag);
    endtask

    int  lat;
    logic seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_ci    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outs", {req_ready, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_out},
              64'd0);
        check("reset alu", {alu_op, alu_ci, alu_a, alu_b}, 64'd0);
        rst_n = 1'b1;

        // Plain ADD from requester 0 (pointer -> 1)
        run_txn("t1 add", 0, 32'd7, 32'd2, 2'b00, 1'b0, 2, 32'd9, 4'b0000, 1'b0);

        // MUL from requester 1 with a long rsp_ready stall (pointer -> 0)
        @(negedge clk);
        set_req(1, 32'd5, 32'd5, 2'b01, 1'b0);
        #1 check("t3 ready", 64'(req_ready), 64'(2'b10));
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(lat);
        check("t3 lat", 64'(lat), 64'd2);
        set_req(1, 32'd9, 32'd9, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1 check("t3 stall", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_out, req_ready},
                     {1'b1, 1'b1, 1'b0, 4'b0000, 32'd25, 2'b00});
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        consume("t3");

        // Both requesters valid with pointer 0
        @(negedge clk);
        set_req(0, 32'd10, 32'd20, 2'b00, 1'b0);
        set_req(1, 32'd3, 32'd4, 2'b00, 1'b1);
        #1 check("t2 first grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        wait_rsp(lat);
        check("t2 rsp a", {rsp_id, rsp_out}, {1'b0, 32'd30});
        consume("t2a");
        check("t2 second grant", 64'(req_ready), 64'(2'b10));
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(lat);
        check("t2 rsp b", {rsp_id, rsp_out}, {1'b1, 32'd8});
        consume("t2b");
        check("t2 third grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(lat);
        check("t2 rsp c", {rsp_id, rsp_out}, {1'b0, 32'd30});
        consume("t2c");

        // Reserved op: immediate error response, ALU inputs untouched
        run_txn("t4 rsv", 0, 32'hDEAD, 32'hBEEF, 2'b11, 1'b1, 1, 32'd0, 4'b0000, 1'b1);
        check("t4 alu hold", {alu_op, alu_ci, alu_a, alu_b}, {2'b00, 1'b0, 32'd10, 32'd20});

        // DIV by zero
`ifdef ALU_DIVZERO_EN
        run_txn("t5 div0", 1, 32'd13, 32'd0, 2'b10, 1'b0, 1, 32'd0, 4'b0000, 1'b1);
        check("t5 alu hold", {alu_op, alu_a}, {2'b00, 32'd10});
`else
        run_txn("t5 div0", 1, 32'd13, 32'd0, 2'b10, 1'b0, 2, 32'hFFFF_FFFF, 4'b1000, 1'b0);
`endif
        run_txn("t5 div", 0, 32'd13, 32'd2, 2'b10, 1'b0, 2, 32'd6, 4'b0000, 1'b0);

        // Flag boundaries: unsigned wrap and signed overflow
        run_txn("add wrap", 1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0, 2, 32'd0, 4'b0110, 1'b0);
        run_txn("add ovf", 0, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0, 2, 32'h8000_0000, 4'b1001,
                1'b0);

        // Reset while waiting on the ALU (pointer was 1 before reset)
        @(negedge clk);
        set_req(0, 32'd1, 32'd2, 2'b00, 1'b0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        set_req(1, 32'd4, 32'd4, 2'b00, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("t6 reset outs", {req_ready, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_out},
                 64'd0);
        check("t6 reset alu", {alu_op, alu_ci, alu_a, alu_b}, 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("t6 no rsp", 64'(seen), 64'd0);
        set_req(0, 32'd100, 32'd23, 2'b00, 1'b0);
        set_req(1, 32'd4, 32'd4, 2'b00, 1'b0);
        #1 check("t6 ptr reset", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(lat);
        check("t6 lat", 64'(lat), 64'd2);
        check("t6 rsp", {rsp_id, rsp_err, rsp_out}, {1'b0, 1'b0, 32'd123});
        consume("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
